// File: rtl/seg7_multi_driver.sv
// Seven-segment driver: latches packed nibbles via valid/ready and drives
// per-digit static segments plus a time-multiplexed scan port (active-low).
module seg7_multi_driver #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_value,
  input  logic                   hex_en,
  input  logic                   lzb_en,
  input  logic [NDIGITS-1:0]     blink_mask,
  output logic [7*NDIGITS-1:0]   leds,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     dig_sel
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'((BLINK_DIV > 0) ? BLINK_DIV - 1 : 0);
  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'((SCAN_DIV > 0) ? SCAN_DIV - 1 : 0);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NDIGITS - 1);
  localparam logic [6:0]         BLANK    = 7'b1111111;

  logic [4*NDIGITS-1:0] value_q;
  logic                 ready_q;
  logic [7*NDIGITS-1:0] leds_q, leds_d;
  logic [6:0]           seg_q, seg_d;
  logic [NDIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [IDX_W-1:0]     scan_idx_q;
  logic [SCAN_W-1:0]    scan_cnt_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_ph_q;

  logic [6:0]           disp [NDIGITS];
  logic                 zrun;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    g = BLANK;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = BLANK;
    endcase
    if (!hex && n >= 4'd10) g = 7'b1001001;
    return g;
  endfunction

  // Walk from the most significant digit so zrun means "this and all higher nibbles are zero".
  always_comb begin
    zrun   = 1'b1;
    leds_d = '1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (value_q[4*i +: 4] == 4'd0);
      if (blink_mask[i] && blink_ph_q)
        disp[i] = BLANK;
      else if (lzb_en && (i > 0) && zrun)
        disp[i] = BLANK;
      else
        disp[i] = glyph(value_q[4*i +: 4], hex_en);
      leds_d[7*i +: 7] = disp[i];
    end
    seg_d     = disp[scan_idx_q];
    dig_sel_d = ~(NDIGITS'(1) << scan_idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q     <= '0;
      ready_q     <= 1'b1;
      leds_q      <= '1;
      seg_q       <= BLANK;
      dig_sel_q   <= '1;
      scan_idx_q  <= '0;
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      if (load_valid && ready_q) begin
        value_q <= load_value;
        ready_q <= 1'b0;
      end else begin
        ready_q <= 1'b1;
      end

      leds_q    <= leds_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;

      if (scan_cnt_q == SCAN_TC) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end

      // A zero divider parks the blink phase in the visible state.
      if (BLINK_DIV == 0) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= 1'b0;
      end else if (blink_cnt_q == BLINK_TC) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign load_ready = ready_q;
  assign leds       = leds_q;
  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;

endmodule

// File: doc/seg7_multi_driver.md
Name: seg7_multi_driver

Overview:
- Parametrised NDIGITS-wide seven-segment display driver for DE1-SoC-class boards with active-low segments.
- Latches a packed nibble value through a valid/ready handshake and drives two output forms:
  - per-digit static segment buses;
  - a time-multiplexed scan port for boards that share segment lines.
- Adds hex/decimal mode, leading-zero blanking and per-digit blink.
- Sits between application status registers and the board's HEX pins.

Parameters:
- NDIGITS, 6, number of digits; legal range 1..8.
- BLINK_DIV, 25000000, clock cycles per blink half-period; 0 disables blink.
- SCAN_DIV, 50000, clock cycles per scan digit slot; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  load request
- load_ready  out  1  driver can accept a load
- load_value  in  4*NDIGITS  packed nibbles; digit i = bits [4i+3:4i], digit 0 is rightmost
- hex_en  in  1  1 = show A-F; 0 = nibbles >= 10 show the error glyph
- lzb_en  in  1  leading-zero blanking enable
- blink_mask  in  NDIGITS  1 = digit blinks
- leds  out  7*NDIGITS  static segments; digit i = bits [7i+6:7i]; bit order g..a, active-low
- seg  out  7  scan segments, same encoding as leds
- dig_sel  out  NDIGITS  scan digit enable, active-low one-hot

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset values:
  - value_q = 0; leds all 1 (blank); seg = 7'h7F; dig_sel all 1.
  - load_ready = 1; scan index = 0; scan counter = 0; blink counter = 0; blink phase = 0 (visible).
- Glyph table, active-low, bit order g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - error glyph = 1001001 (used when hex_en=0 and nibble >= 10)
  - blank = 1111111
- Handshake:
  - Accept occurs on an edge where load_valid && load_ready; value_q <= load_value at that edge.
  - load_ready is low for exactly one cycle after an accept, then high again.
  - load_valid while load_ready=0 is ignored; the value is not queued.
- Latency:
  - leds and seg reflect a new value_q at the next edge after the accept, i.e. 1 cycle.
  - Changes on hex_en, lzb_en and blink_mask appear on the outputs 1 cycle later.
- Per-digit blanking, evaluated in priority order:
  1. Blink blank: blink_mask[i] && blink phase=1.
  2. Leading-zero blank: lzb_en && i>0 && nibbles i..NDIGITS-1 all zero.
  3. Otherwise the glyph from the table.
  - Digit 0 is never leading-zero blanked.
- Blink timer:
  - Counter counts 0..BLINK_DIV-1; the phase toggles on wrap.
  - BLINK_DIV=0 holds the phase at 0.
- Scan timer:
  - Counter counts 0..SCAN_DIV-1; on wrap the scan index increments, and NDIGITS-1 wraps to 0.
  - Each cycle: dig_sel <= ~(1<<index) and seg <= the glyph of digit index, with the same blanking as leds.
  - The first cycle after reset drives digit 0.
- Simultaneous events: an accept, a blink toggle and a scan advance in the same cycle all take effect together; none is dropped or delayed.
- Reset mid-operation:
  - Any load in flight is discarded.
  - All outputs return to their reset values at that edge.
- Counter widths are $clog2-derived; no overflow is permitted beyond the DIV-1 terminal values.

Test Plan:
- NDIGITS=4, BLINK_DIV=0, SCAN_DIV=2; hold rst 2 cycles → leds=28'hFFFFFFF, seg=7'h7F, dig_sel=4'hF, load_ready=1.
- load_value=16'h09A5, hex_en=1, lzb_en=0, one-cycle valid → load_ready=0 next cycle, then 1.
  - One cycle after accept, digits 3..0 = 1000000, 0010000, 0001000, 0010010.
- Same value with hex_en=0 → digit 1 = 1001001.
- lzb_en=1, value=16'h0040 → digit3 blank, digit2 blank, digit1 = 0011001, digit0 = 1000000.
- value=16'h0000 with lzb_en=1 → only digit0 lit (1000000).
- Back-to-back load_valid for 3 cycles with values 1111, 2222, 3333 → accepts 1111 and 3333 only; final leds show 3333.
- BLINK_DIV=8, blink_mask=4'b0010 → digit1 alternates glyph/blank every 8 cycles; the other digits stay steady.
- SCAN_DIV=2 → dig_sel sequence E,E,D,D,B,B,7,7,E; seg matches the selected digit each cycle.
- Assert rst while an accept is in progress → outputs blank next edge and value_q=0.
- After reset, first load succeeds with 1-cycle latency.
